// File: rtl/wm_phase_timer.sv
// Per-phase duration timer for the washing-machine controller: loads a duration on phase entry,
// counts it down in prescaled ticks and raises the matching timer_* done flag. WM_PAUSE_EN adds a pause input.
module wm_phase_timer #(
    parameter int TICK_DIV    = 4,
    parameter int CNT_W       = 8,
    parameter int SOAK_LOW_T  = 3,
    parameter int SOAK_HIGH_T = 5,
    parameter int WASH_LOW_T  = 4,
    parameter int WASH_HIGH_T = 6,
    parameter int RINSE_T     = 3,
    parameter int SPIN_T      = 4,
    parameter int DRAIN_T     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             idle,
    input  logic             soak_low,
    input  logic             soak_high,
    input  logic             wash_low,
    input  logic             wash_high,
    input  logic             rinse,
    input  logic             spin,
    input  logic             drain,
`ifdef WM_PAUSE_EN
    input  logic             pause,
`endif
    output logic             timer_soak_low,
    output logic             timer_soak_high,
    output logic             timer_wash_low,
    output logic             timer_wash_high,
    output logic             timer_rinse,
    output logic             timer_spin,
    output logic             timer_drain,
    output logic [CNT_W-1:0] remaining,
    output logic             busy,
    output logic             phase_err
);

    // state        | meaning
    // PH_NONE      | no valid phase (idle, all low, or multi-hot)
    // PH_SOAK_LOW  | soak_low active ... PH_DRAIN | drain active
    typedef enum logic [2:0] {
        PH_NONE      = 3'd0,
        PH_SOAK_LOW  = 3'd1,
        PH_SOAK_HIGH = 3'd2,
        PH_WASH_LOW  = 3'd3,
        PH_WASH_HIGH = 3'd4,
        PH_RINSE     = 3'd5,
        PH_SPIN      = 3'd6,
        PH_DRAIN     = 3'd7
    } phase_t;

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    // zero durations are clamped to one tick so every phase produces a done flag
    localparam logic [CNT_W-1:0] D_SOAK_LOW  = CNT_W'((SOAK_LOW_T  < 1) ? 1 : SOAK_LOW_T);
    localparam logic [CNT_W-1:0] D_SOAK_HIGH = CNT_W'((SOAK_HIGH_T < 1) ? 1 : SOAK_HIGH_T);
    localparam logic [CNT_W-1:0] D_WASH_LOW  = CNT_W'((WASH_LOW_T  < 1) ? 1 : WASH_LOW_T);
    localparam logic [CNT_W-1:0] D_WASH_HIGH = CNT_W'((WASH_HIGH_T < 1) ? 1 : WASH_HIGH_T);
    localparam logic [CNT_W-1:0] D_RINSE     = CNT_W'((RINSE_T     < 1) ? 1 : RINSE_T);
    localparam logic [CNT_W-1:0] D_SPIN      = CNT_W'((SPIN_T      < 1) ? 1 : SPIN_T);
    localparam logic [CNT_W-1:0] D_DRAIN     = CNT_W'((DRAIN_T     < 1) ? 1 : DRAIN_T);

    function automatic logic [CNT_W-1:0] phase_duration(input phase_t p);
        case (p)
            PH_SOAK_LOW:  return D_SOAK_LOW;
            PH_SOAK_HIGH: return D_SOAK_HIGH;
            PH_WASH_LOW:  return D_WASH_LOW;
            PH_WASH_HIGH: return D_WASH_HIGH;
            PH_RINSE:     return D_RINSE;
            PH_SPIN:      return D_SPIN;
            PH_DRAIN:     return D_DRAIN;
            default:      return '0;
        endcase
    endfunction

    function automatic logic [6:0] phase_mask(input phase_t p);
        case (p)
            PH_SOAK_LOW:  return 7'b0000001;
            PH_SOAK_HIGH: return 7'b0000010;
            PH_WASH_LOW:  return 7'b0000100;
            PH_WASH_HIGH: return 7'b0001000;
            PH_RINSE:     return 7'b0010000;
            PH_SPIN:      return 7'b0100000;
            PH_DRAIN:     return 7'b1000000;
            default:      return 7'b0000000;
        endcase
    endfunction

    // idle decodes to PH_NONE exactly like all-phases-low, so it carries no extra information
    logic unused_idle;
    assign unused_idle = idle;

    logic freeze;
`ifdef WM_PAUSE_EN
    assign freeze = pause;
`else
    assign freeze = 1'b0;
`endif

    logic [6:0]       phase_vec;
    phase_t           phase_d;
    logic             multi_hot;

    phase_t           prev_q, prev_nxt;
    logic [CNT_W-1:0] rem_q, rem_nxt;
    logic [PRE_W-1:0] pre_q, pre_nxt;
    logic [6:0]       tmr_q, tmr_nxt;
    logic             busy_q;
    logic             err_q;

    assign phase_vec = {drain, spin, rinse, wash_high, wash_low, soak_high, soak_low};

    always_comb begin
        phase_d   = PH_NONE;
        multi_hot = ($countones(phase_vec) > 1);
        case (phase_vec)
            7'b0000001: phase_d = PH_SOAK_LOW;
            7'b0000010: phase_d = PH_SOAK_HIGH;
            7'b0000100: phase_d = PH_WASH_LOW;
            7'b0001000: phase_d = PH_WASH_HIGH;
            7'b0010000: phase_d = PH_RINSE;
            7'b0100000: phase_d = PH_SPIN;
            7'b1000000: phase_d = PH_DRAIN;
            default:    phase_d = PH_NONE;
        endcase
    end

    always_comb begin
        prev_nxt = prev_q;
        rem_nxt  = rem_q;
        pre_nxt  = pre_q;
        tmr_nxt  = tmr_q;
        if (phase_d != prev_q) begin
            // entry or drop to NONE overrides both a pending tick and pause
            prev_nxt = phase_d;
            pre_nxt  = '0;
            tmr_nxt  = '0;
            rem_nxt  = phase_duration(phase_d);
        end else if ((rem_q != '0) && !freeze) begin
            if (pre_q == PRE_MAX) begin
                pre_nxt = '0;
                rem_nxt = rem_q - 1'b1;
                if (rem_q == CNT_W'(1)) begin
                    tmr_nxt = phase_mask(prev_q);
                end
            end else begin
                pre_nxt = pre_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= PH_NONE;
            rem_q  <= '0;
            pre_q  <= '0;
            tmr_q  <= '0;
            busy_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            prev_q <= prev_nxt;
            rem_q  <= rem_nxt;
            pre_q  <= pre_nxt;
            tmr_q  <= tmr_nxt;
            busy_q <= (rem_nxt != '0);
            err_q  <= multi_hot;
        end
    end

    assign timer_soak_low  = tmr_q[0];
    assign timer_soak_high = tmr_q[1];
    assign timer_wash_low  = tmr_q[2];
    assign timer_wash_high = tmr_q[3];
    assign timer_rinse     = tmr_q[4];
    assign timer_spin      = tmr_q[5];
    assign timer_drain     = tmr_q[6];
    assign remaining       = rem_q;
    assign busy            = busy_q;
    assign phase_err       = err_q;

endmodule

// File: tb/tb_wm_phase_timer.sv
// Bench for wm_phase_timer: directed phase scenarios plus random phase traffic, compared every cycle
// against an elapsed-time model. Exercises pause when WM_PAUSE_EN is defined.
module tb_wm_phase_timer;

    localparam int TICK = 4;
    localparam int DUR [8] = '{0, 3, 5, 4, 6, 3, 4, 2};

    logic       clk = 1'b0;
    logic       rst;
    logic       idle;
    logic [6:0] ph;
    logic       pause_m;
    logic [7:0] remaining;
    logic       busy, phase_err;
    logic       t_sl, t_sh, t_wl, t_wh, t_ri, t_sp, t_dr;
    logic [6:0] tvec;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    int cur     = 0;
    int elapsed = 0;
    int err_m   = 0;

    always #5 clk = ~clk;

    assign tvec = {t_dr, t_sp, t_ri, t_wh, t_wl, t_sh, t_sl};

    wm_phase_timer dut (
        .clk            (clk),
        .rst            (rst),
        .idle           (idle),
        .soak_low       (ph[0]),
        .soak_high      (ph[1]),
        .wash_low       (ph[2]),
        .wash_high      (ph[3]),
        .rinse          (ph[4]),
        .spin           (ph[5]),
        .drain          (ph[6]),
`ifdef WM_PAUSE_EN
        .pause          (pause_m),
`endif
        .timer_soak_low (t_sl),
        .timer_soak_high(t_sh),
        .timer_wash_low (t_wl),
        .timer_wash_high(t_wh),
        .timer_rinse    (t_ri),
        .timer_spin     (t_sp),
        .timer_drain    (t_dr),
        .remaining      (remaining),
        .busy           (busy),
        .phase_err      (phase_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%0d want=%0d", tag, cyc, obs, exp);
        end
    endtask

    // Model: ticks elapsed since entry determine remaining; done when the duration has fully elapsed
    task automatic step();
        int n;
        int p;
        int rem;
        int mask;
        @(posedge clk);
        if (rst) begin
            cur = 0; elapsed = 0; err_m = 0;
        end else begin
            n = $countones(ph);
            p = 0;
            if (n == 1) begin
                for (int i = 0; i < 7; i++) if (ph[i]) p = i + 1;
            end
            err_m = (n > 1) ? 1 : 0;
            if (p != cur) begin
                cur = p; elapsed = 0;
            end else if (cur != 0 && !pause_m) begin
                elapsed++;
            end
        end
        #1;
        cyc++;
        rem = (cur == 0) ? 0 : DUR[cur] - elapsed / TICK;
        if (rem < 0) rem = 0;
        mask = (cur != 0 && rem == 0) ? (1 << (cur - 1)) : 0;
        check("remaining", 32'(remaining), 32'(rem));
        check("busy", 32'(busy), 32'(rem != 0));
        check("timers", 32'(tvec), 32'(mask));
        check("phase_err", 32'(phase_err), 32'(err_m));
        check("timer_onehot", 32'($countones(tvec) <= 1), 32'd1);
    endtask

    task automatic set_phase(input logic [6:0] v);
        ph   = v;
        idle = (v == 7'd0);
    endtask

    initial begin
        int r, a, b, len;
        rst = 1'b1; pause_m = 1'b0;
        set_phase(7'd0);
        repeat (2) step();
        rst = 1'b0;

        // idle only
        repeat (50) step();

        // soak_high held past done, then straight into wash_high
        set_phase(7'b0000010);
        repeat (22) step();
        set_phase(7'b0001000);
        repeat (26) step();

        // reset mid drain, drain still high afterwards
        set_phase(7'b1000000);
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (10) step();

        // rinse and spin together for one cycle
        set_phase(7'b0110000);
        step();
        set_phase(7'd0);
        repeat (3) step();

`ifdef WM_PAUSE_EN
        // pause during spin, then drain entered while paused
        set_phase(7'b0100000);
        repeat (5) step();
        pause_m = 1'b1;
        repeat (7) step();
        repeat (14) step();
        pause_m = 1'b0;
        repeat (6) step();
        pause_m = 1'b1;
        set_phase(7'b1000000);
        repeat (3) step();
        pause_m = 1'b0;
        repeat (12) step();
`endif

        // random phase traffic
        repeat (70) begin
            r   = $urandom_range(0, 9);
            len = $urandom_range(1, 30);
            if (r <= 1) begin
                set_phase(7'd0);
            end else if (r <= 7) begin
                set_phase(7'(1 << $urandom_range(0, 6)));
            end else if (r == 8) begin
                a = $urandom_range(0, 6);
                b = (a + $urandom_range(1, 6)) % 7;
                set_phase(7'((1 << a) | (1 << b)));
                len = $urandom_range(1, 3);
            end else begin
                rst = 1'b1;
                len = 1;
            end
            repeat (len) begin
`ifdef WM_PAUSE_EN
                pause_m = ($urandom_range(0, 7) == 0);
`endif
                step();
            end
            rst = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
